// File: rtl/cordic_pkg.sv
// Shared CORDIC definitions: FSM state encoding, gain-compensation constant
// and the arctangent table generator used by the vectoring and rotating cores.
// No ports; imported with `import cordic_pkg::*;`.
package cordic_pkg;

    // Sequencer states of the iterative core. S_GAIN is only visited when
    // the gain-compensation build option is enabled.
    typedef enum logic [2:0] {
        S_IDLE,
        S_PRE,
        S_ITER,
        S_GAIN,
        S_DONE
    } cordic_state_t;

    // 1/K for the CORDIC gain K ~= 1.64676, in Q15 (0.607253 * 2^15).
    localparam int CORDIC_INV_GAIN = 19898;

    // Returns round(atan(2^-k) * 2^(phase_w-1) / pi) for phase_w <= 32.
    // The table is held at 32-bit binary-angle resolution (2^31 == pi) and
    // rounded down to the requested phase width, so one table serves every
    // PHASE_W. Entries beyond k=30 round to zero at any supported width.
    function automatic logic [31:0] atan_scaled(input int k, input int phase_w);
        logic [31:0] a;
        case (k)
            0:       a = 32'h2000_0000;
            1:       a = 32'h12E4_051E;
            2:       a = 32'h09FB_385B;
            3:       a = 32'h0511_11D4;
            4:       a = 32'h028B_0D43;
            5:       a = 32'h0145_D7E1;
            6:       a = 32'h00A2_F61E;
            7:       a = 32'h0051_7C55;
            8:       a = 32'h0028_BE53;
            9:       a = 32'h0014_5F2F;
            10:      a = 32'h000A_2F98;
            11:      a = 32'h0005_17CC;
            12:      a = 32'h0002_8BE6;
            13:      a = 32'h0001_45F3;
            14:      a = 32'h0000_A2FA;
            15:      a = 32'h0000_517D;
            16:      a = 32'h0000_28BE;
            17:      a = 32'h0000_145F;
            18:      a = 32'h0000_0A30;
            19:      a = 32'h0000_0518;
            20:      a = 32'h0000_028C;
            21:      a = 32'h0000_0146;
            22:      a = 32'h0000_00A3;
            23:      a = 32'h0000_0051;
            24:      a = 32'h0000_0029;
            25:      a = 32'h0000_0014;
            26:      a = 32'h0000_000A;
            27:      a = 32'h0000_0005;
            28:      a = 32'h0000_0003;
            29:      a = 32'h0000_0001;
            30:      a = 32'h0000_0001;
            default: a = 32'h0000_0000;
        endcase
        // Round-half-up when narrowing; the largest entry (2^29) leaves
        // ample headroom for the rounding increment.
        if (phase_w < 32) begin
            a = (a + (32'd1 << (31 - phase_w))) >> (32 - phase_w);
        end
        return a;
    endfunction

endpackage

// File: rtl/cordic_atan_rom.sv
// Arctangent lookup for CORDIC micro-rotation k, in PHASE_W-bit binary angle.
// Purely combinational; no latency, no flow control.
// Ports: k (iteration index) in, atan (round(atan(2^-k) * 2^(PHASE_W-1)/pi)) out.
module cordic_atan_rom
    import cordic_pkg::*;
#(
    parameter int PHASE_W = 16,   // 1..32
    parameter int CNT_W   = 4
) (
    input  logic [CNT_W-1:0]   k,
    output logic [PHASE_W-1:0] atan
);

    // Constant PHASE_W argument lets synthesis fold this into a small ROM.
    always_comb begin
        atan = PHASE_W'(atan_scaled(int'(k), PHASE_W));
    end

endmodule

// File: rtl/cordic_vector.sv
// Iterative vectoring-mode CORDIC: (I,Q) -> phase (binary angle) and magnitude.
// Latency ITER+2 clocks from accept to ovalid (ITER+3 with CORDIC_GAIN_COMP_EN).
// One sample in flight; iready low while busy, ivalid without iready is dropped.
//
// Ports:
//   clock, reset          rising-edge clock, synchronous active-high reset
//   ivalid / iready       sample handshake, accepted when both are high
//   idata_r, idata_i      signed I and Q, DATA_W bits
//   ovalid                one-cycle result strobe
//   phase                 signed angle, +pi = 2^(PHASE_W-1), wraps
//   magnitude             unsigned |I+jQ|, DATA_W+2 bits, held until next result
//
// Build option: define CORDIC_GAIN_COMP_EN to scale magnitude by 1/K in an
// extra GAIN cycle; otherwise magnitude is the raw CORDIC x (gain ~1.64676).
module cordic_vector
    import cordic_pkg::*;
#(
    parameter int DATA_W  = 16,
    parameter int PHASE_W = 16,
    parameter int ITER    = 14     // 4..PHASE_W-1
) (
    input  logic                      clock,
    input  logic                      reset,
    input  logic                      ivalid,
    output logic                      iready,
    input  logic signed [DATA_W-1:0]  idata_r,
    input  logic signed [DATA_W-1:0]  idata_i,
    output logic                      ovalid,
    output logic signed [PHASE_W-1:0] phase,
    output logic [DATA_W+1:0]         magnitude
);

    // Two guard bits absorb the sqrt(2) of a full-scale corner input times
    // the CORDIC gain (~2.33 in total).
    localparam int XW    = DATA_W + 2;
    localparam int CNT_W = $clog2(ITER);

    cordic_state_t state, state_nxt;

    logic signed [XW-1:0] x, y;
    logic signed [XW-1:0] x_sh, y_sh;
    logic signed [XW-1:0] x_step, y_step;
    logic [PHASE_W-1:0]   z, z_step;
    logic [PHASE_W-1:0]   atan_k;
    logic [CNT_W-1:0]     k;
    logic                 k_last;

    logic [PHASE_W-1:0]   phase_q;
    logic [XW-1:0]        mag_q;

    assign k_last = (k == CNT_W'(ITER - 1));

    cordic_atan_rom #(
        .PHASE_W (PHASE_W),
        .CNT_W   (CNT_W)
    ) u_atan_rom (
        .k    (k),
        .atan (atan_k)
    );

    // ------------------------------------------------------------------
    // Sequencer
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            S_IDLE: begin
                if (ivalid) begin
                    state_nxt = S_PRE;
                end
            end
            S_PRE: begin
                state_nxt = S_ITER;
            end
            S_ITER: begin
                if (k_last) begin
`ifdef CORDIC_GAIN_COMP_EN
                    state_nxt = S_GAIN;
`else
                    state_nxt = S_DONE;
`endif
                end
            end
            S_GAIN: begin
                state_nxt = S_DONE;
            end
            S_DONE: begin
                state_nxt = S_IDLE;
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase
    end

    // Gated with reset so both strobes are low for every cycle reset is high,
    // including the first one before the state register has been cleared.
    assign iready = (state == S_IDLE) && !reset;
    assign ovalid = (state == S_DONE) && !reset;

    // ------------------------------------------------------------------
    // Micro-rotation: drive y toward zero, accumulating the applied angle.
    // ------------------------------------------------------------------
    always_comb begin
        x_sh = x >>> k;
        y_sh = y >>> k;
        if (!y[XW-1]) begin
            x_step = x + y_sh;
            y_step = y - x_sh;
            z_step = z + atan_k;
        end else begin
            x_step = x - y_sh;
            y_step = y + x_sh;
            z_step = z - atan_k;
        end
        // x never decreases once non-negative and becomes |y| at k=0, so
        // x==y==0 only occurs for a zero input; freezing z there reports a
        // phase of 0 instead of the sum of every table entry.
        if ((x == '0) && (y == '0)) begin
            z_step = z;
        end
    end

`ifdef CORDIC_GAIN_COMP_EN
    // x is non-negative here, so an unsigned multiply is exact. Adding
    // 2^14 before dropping 15 fraction bits rounds to nearest.
    logic [XW+14:0] gain_prod;
    assign gain_prod = (XW+15)'($unsigned(x)) * (XW+15)'(CORDIC_INV_GAIN)
                     + (XW+15)'(1 << 14);
`endif

    // ------------------------------------------------------------------
    // Datapath registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock) begin
        if (reset) begin
            x       <= '0;
            y       <= '0;
            z       <= '0;
            k       <= '0;
            phase_q <= '0;
            mag_q   <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    // Capture raw sign-extended sample; folding happens in PRE.
                    if (ivalid) begin
                        x <= {{2{idata_r[DATA_W-1]}}, idata_r};
                        y <= {{2{idata_i[DATA_W-1]}}, idata_i};
                    end
                end
                S_PRE: begin
                    // Fold left half-plane onto the right by a pi rotation so the
                    // micro-rotations (which span ~+/-99.9 deg) always converge.
                    if (x[XW-1]) begin
                        x <= -x;
                        y <= -y;
                        z <= {1'b1, {(PHASE_W-1){1'b0}}};
                    end else begin
                        z <= '0;
                    end
                    k <= '0;
                end
                S_ITER: begin
                    x <= x_step;
                    y <= y_step;
                    z <= z_step;
                    k <= k + 1'b1;
`ifndef CORDIC_GAIN_COMP_EN
                    if (k_last) begin
                        phase_q <= z_step;
                        mag_q   <= x_step;
                    end
`endif
                end
`ifdef CORDIC_GAIN_COMP_EN
                S_GAIN: begin
                    phase_q <= z;
                    mag_q   <= XW'(gain_prod >> 15);
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign phase     = phase_q;
    assign magnitude = mag_q;

endmodule

// File: tb/tb_cordic_vector.sv
module tb_cordic_vector;

    localparam int DATA_W  = 16;
    localparam int PHASE_W = 16;
    localparam int ITER    = 14;
`ifdef CORDIC_GAIN_COMP_EN
    localparam int LAT  = ITER + 3;
    localparam bit COMP = 1'b1;
    localparam int MTOL = 2;
`else
    localparam int LAT  = ITER + 2;
    localparam bit COMP = 1'b0;
    localparam int MTOL = 4;
`endif
    localparam int PTOL = 4;
    localparam real PI = 3.14159265358979323846;

    logic                      clock = 1'b0;
    logic                      reset = 1'b1;
    logic                      ivalid = 1'b0;
    logic                      iready;
    logic signed [DATA_W-1:0]  idata_r = '0;
    logic signed [DATA_W-1:0]  idata_i = '0;
    logic                      ovalid;
    logic signed [PHASE_W-1:0] phase;
    logic [DATA_W+1:0]         magnitude;

    cordic_vector #(
        .DATA_W  (DATA_W),
        .PHASE_W (PHASE_W),
        .ITER    (ITER)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .ivalid    (ivalid),
        .iready    (iready),
        .idata_r   (idata_r),
        .idata_i   (idata_i),
        .ovalid    (ovalid),
        .phase     (phase),
        .magnitude (magnitude)
    );

    always #5 clock = ~clock;

    int  n_cmp = 0;
    int  n_bad = 0;
    real mag_scale;

    function automatic int rnd(input real r);
        return (r >= 0.0) ? $rtoi(r + 0.5) : -$rtoi(0.5 - r);
    endfunction

    // wrap=1 compares modulo 2^PHASE_W (phase near +/-pi).
    task automatic check(input string tag, input int obs, input int exp,
                         input int tol, input bit wrap);
        int d;
        logic signed [PHASE_W-1:0] d16;
        n_cmp++;
        d = obs - exp;
        if (wrap) begin
            d16 = PHASE_W'(d);
            d = int'(d16);
        end
        if (d < 0) d = -d;
        assert (d <= tol) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d (tol %0d)", tag, obs, exp, tol);
        end
    endtask

    // Present one sample, wait for acceptance, then wait for the result.
    // lat counts cycles from the accept cycle to the ovalid cycle.
    task automatic run_sample(input int ir, input int ii, output int ph,
                              output int mg, output int lat, output bit got);
        int n;
        @(negedge clock);
        idata_r = DATA_W'(ir);
        idata_i = DATA_W'(ii);
        ivalid  = 1'b1;
        n = 0;
        while (!iready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        ivalid = 1'b0;
        lat = 1;
        while (!ovalid && lat < 60) begin
            @(negedge clock);
            lat++;
        end
        got = ovalid;
        ph  = int'(phase);
        mg  = int'(magnitude);
    endtask

    task automatic do_vec(input string tag, input int ir, input int ii,
                          input int ph_exp, input real mag_true,
                          input int ptol, input int mtol);
        int ph, mg, lat;
        bit got;
        run_sample(ir, ii, ph, mg, lat, got);
        check({tag, "_ovalid"}, int'(got), 1, 0, 1'b0);
        check({tag, "_phase"}, ph, ph_exp, ptol, 1'b1);
        check({tag, "_mag"}, mg, rnd(mag_true * mag_scale), mtol, 1'b0);
    endtask

    initial begin
        int ph, mg, lat, ov_cnt, n, p, ir, ii;
        bit got;
        real g, s, a;

        // Expected raw gain of ITER micro-rotations (unused when compensated).
        g = 1.0;
        s = 1.0;
        for (int i = 0; i < ITER; i++) begin
            g = g * $sqrt(1.0 + s * s);
            s = s / 2.0;
        end
        mag_scale = COMP ? 1.0 : g;

        // Reset state
        repeat (3) @(negedge clock);
        check("rst_ovalid", int'(ovalid), 0, 0, 1'b0);
        check("rst_iready", int'(iready), 0, 0, 1'b0);
        check("rst_phase", int'(phase), 0, 0, 1'b0);
        check("rst_mag", int'(magnitude), 0, 0, 1'b0);
        reset = 1'b0;
        @(negedge clock);
        check("rel_iready", int'(iready), 1, 0, 1'b0);

        // First sample with exact latency
        run_sample(16384, 0, ph, mg, lat, got);
        check("lat_16384_0", lat, LAT, 0, 1'b0);
        check("v0_phase", ph, 0, PTOL, 1'b1);
        check("v0_mag", mg, rnd(16384.0 * mag_scale), MTOL, 1'b0);

        // Directed vectors
        do_vec("q90", 0, 16384, 16384, 16384.0, PTOL, MTOL);
        do_vec("pi", -16384, 0, -32768, 16384.0, PTOL, MTOL);
        do_vec("m90", 0, -16384, -16384, 16384.0, PTOL, MTOL);
        do_vec("m45", 10000, -10000, -8192, 14142.1356, PTOL, MTOL);
        do_vec("fullscale", -32768, -32768, -24576, 46340.95, PTOL, MTOL);
        do_vec("zero", 0, 0, 0, 0.0, 0, 0);

        // Second ivalid while busy is ignored
        @(negedge clock);
        idata_r = 16'sd3000;
        idata_i = 16'sd4000;
        ivalid  = 1'b1;
        n = 0;
        while (!iready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        check("busy_iready", int'(iready), 0, 0, 1'b0);
        idata_r = -16'sd16384;
        idata_i = 16'sd0;
        @(negedge clock);
        ivalid = 1'b0;
        ov_cnt = 0;
        ph = 0;
        mg = 0;
        for (int c = 0; c < 40; c++) begin
            if (ovalid) begin
                ov_cnt++;
                ph = int'(phase);
                mg = int'(magnitude);
            end
            @(negedge clock);
        end
        check("busy_ovalid_count", ov_cnt, 1, 0, 1'b0);
        check("busy_phase", ph, 9672, PTOL, 1'b1);
        check("busy_mag", mg, rnd(5000.0 * mag_scale), MTOL, 1'b0);

        // Reset during iteration k=5 aborts without a result
        @(negedge clock);
        idata_r = 16'sd20000;
        idata_i = 16'sd7000;
        ivalid  = 1'b1;
        n = 0;
        while (!iready && n < 50) begin
            @(negedge clock);
            n++;
        end
        @(negedge clock);
        ivalid = 1'b0;
        ov_cnt = 0;
        repeat (6) begin
            @(negedge clock);
            if (ovalid) ov_cnt++;
        end
        reset = 1'b1;
        @(negedge clock);
        check("abort_rst_iready", int'(iready), 0, 0, 1'b0);
        check("abort_rst_phase", int'(phase), 0, 0, 1'b0);
        check("abort_rst_mag", int'(magnitude), 0, 0, 1'b0);
        if (ovalid) ov_cnt++;
        reset = 1'b0;
        @(negedge clock);
        check("abort_rel_iready", int'(iready), 1, 0, 1'b0);
        repeat (30) begin
            if (ovalid) ov_cnt++;
            @(negedge clock);
        end
        check("abort_no_ovalid", ov_cnt, 0, 0, 1'b0);
        do_vec("post_abort", 12000, 5000, 4118, 13000.0, PTOL, MTOL);

        // Round trip: ideal rotator output for (16384,0) at phase p
        for (int i = 0; i < 64; i++) begin
            p  = -32768 + i * 1024;
            a  = p * PI / 32768.0;
            ir = rnd(16384.0 * $cos(a));
            ii = rnd(16384.0 * $sin(a));
            run_sample(ir, ii, ph, mg, lat, got);
            check($sformatf("sweep_%0d_phase", p), ph, p, PTOL, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
